// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-side memory access unit: access sizes, FSM states,
// address-error exception codes and the alignment rule.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } mau_state_t;

  // A dword access on a 32-bit datapath has no legal alignment, so it always faults.
  function automatic logic addr_misaligned(input logic [2:0] lo, input logic [1:0] size,
                                           input logic dword_ok);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = |lo[1:0];
      default: mis = dword_ok ? |lo : 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane alignment: replicates store data across lanes and extracts/extends the
// sized load field selected by the lane index.
module mau_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int LANE_W = $clog2(NB)
) (
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [LANE_W-1:0] i_lane,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_mask;
  logic              w_sign;

  always_comb begin
    case (i_size)
      SZ_BYTE: o_wdata = {NB{i_wdata[7:0]}};
      SZ_HALF: o_wdata = {(NB/2){i_wdata[15:0]}};
      SZ_WORD: o_wdata = {(NB/4){i_wdata[31:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

  assign w_shift = i_rdata >> {i_lane, 3'b000};

  // The mask keeps the sized field; its complement is filled with the sign for signed loads.
  always_comb begin
    case (i_size)
      SZ_BYTE: begin w_mask = {DATA_W{1'b1}} >> (DATA_W - 8);  w_sign = w_shift[7];  end
      SZ_HALF: begin w_mask = {DATA_W{1'b1}} >> (DATA_W - 16); w_sign = w_shift[15]; end
      SZ_WORD: begin w_mask = {DATA_W{1'b1}} >> (DATA_W - 32); w_sign = w_shift[31]; end
      default: begin w_mask = {DATA_W{1'b1}};                  w_sign = w_shift[DATA_W-1]; end
    endcase
  end

  assign o_rdata = (w_shift & w_mask) | ((!i_unsigned && w_sign) ? ~w_mask : '0);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data access unit: load/store to SRAM-like req/addr_ok/data_ok bus with
// alignment checks, stall and flush/drain handling. Optional counters: MAU_PERF_CNT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  input  logic              acc_valid,
  input  logic              acc_wr,
  input  logic [1:0]        acc_size,
  input  logic              acc_unsigned,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  input  logic              exc_in,
  input  logic              flush,
  input  logic              pipe_go,
  output logic              stall_o,
  output logic              exc_adel_o,
  output logic              exc_ades_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              done_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
`ifdef MAU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_acc_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  localparam int LANE_W = $clog2(DATA_W / 8);

  mau_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_wr;
  logic              r_unsigned;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_ld_data;

  logic              w_idle;
  logic              w_misalign;
  logic              w_acc_ok;
  logic              w_launch;
  logic              w_retire;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [1:0]        w_sel_size;
  logic              w_sel_unsigned;
  logic [DATA_W-1:0] w_rep_wdata;
  logic [DATA_W-1:0] w_ext_rdata;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_misalign = addr_misaligned(acc_addr[2:0], acc_size, DATA_W == 64);
  assign w_acc_ok   = acc_valid & !exc_in & !w_misalign;
  assign w_launch   = w_idle & w_acc_ok & !flush;

  assign exc_adel_o = acc_valid & !acc_wr & w_misalign & !exc_in;
  assign exc_ades_o = acc_valid &  acc_wr & w_misalign & !exc_in;

  // At launch the pipeline fields drive the aligner directly; afterwards the latched copy does.
  assign w_sel_addr     = w_idle ? acc_addr     : r_addr;
  assign w_sel_size     = w_idle ? acc_size     : r_size;
  assign w_sel_unsigned = w_idle ? acc_unsigned : r_unsigned;

  mau_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .i_size     (w_sel_size),
    .i_unsigned (w_sel_unsigned),
    .i_lane     (w_sel_addr[LANE_W-1:0]),
    .i_wdata    (acc_wdata),
    .i_rdata    (data_rdata),
    .o_wdata    (w_rep_wdata),
    .o_rdata    (w_ext_rdata)
  );

  assign w_retire = data_data_ok & !flush &
                    ((w_launch & data_addr_ok) |
                     ((r_state == ST_REQ) & data_addr_ok) |
                     (r_state == ST_WAIT));

  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = '0;
    data_addr  = '0;
    data_wdata = '0;
    if (w_launch) begin
      data_req   = 1'b1;
      data_wr    = acc_wr;
      data_size  = acc_size;
      data_addr  = acc_addr;
      data_wdata = w_rep_wdata;
    end else if (r_state == ST_REQ) begin
      data_req   = 1'b1;
      data_wr    = r_wr;
      data_size  = r_size;
      data_addr  = r_addr;
      data_wdata = r_wdata;
    end
  end

  // While draining, a fresh access must wait for the stale data_ok, so it is stalled.
  assign stall_o   = w_launch | (r_state == ST_REQ) | (r_state == ST_WAIT) |
                     ((r_state == ST_DRAIN) & w_acc_ok);
  assign done_o    = (r_state == ST_DONE);
  assign ld_data_o = r_ld_data;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_size     <= '0;
      r_wr       <= 1'b0;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_ld_data  <= '0;
    end else begin
      if (w_retire) begin
        r_ld_data <= w_ext_rdata;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_addr     <= acc_addr;
            r_size     <= acc_size;
            r_wr       <= acc_wr;
            r_unsigned <= acc_unsigned;
            r_wdata    <= w_rep_wdata;
            if (w_retire)          r_state <= ST_DONE;
            else if (data_addr_ok) r_state <= ST_WAIT;
            else                   r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_retire)                          r_state <= ST_DONE;
          else if (data_addr_ok & data_data_ok)  r_state <= ST_IDLE;
          else if (data_addr_ok)                 r_state <= flush ? ST_DRAIN : ST_WAIT;
          else if (flush)                        r_state <= ST_IDLE;
        end
        ST_WAIT: begin
          if (w_retire)          r_state <= ST_DONE;
          else if (data_data_ok) r_state <= ST_IDLE;
          else if (flush)        r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (data_data_ok) r_state <= ST_IDLE;
        end
        ST_DONE: begin
          if (pipe_go | flush) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MAU_PERF_CNT_EN
  logic [31:0] r_perf_acc;
  logic [31:0] r_perf_stall;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_perf_acc   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_retire && (r_perf_acc != 32'hFFFF_FFFF))   r_perf_acc   <= r_perf_acc + 32'd1;
      if (stall_o && (r_perf_stall != 32'hFFFF_FFFF)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_acc_cnt_o   = r_perf_acc;
  assign perf_stall_cnt_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a 32-bit and a 64-bit instance share the
// bus response signals; load results are checked against a scoreboard queue.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid32, valid64;
  logic        accWr, accUns, excIn, flush, pipeGo;
  logic [1:0]  accSize;
  logic [31:0] accAddr;
  logic [63:0] accWdata;
  logic        addrOk, dataOk;
  logic [63:0] dataRdata;

  logic        stall32, adel32, ades32, done32, req32, wr32;
  logic [1:0]  size32;
  logic [31:0] addr32, wdata32, ld32;
  logic        stall64, adel64, ades64, done64, req64, wr64;
  logic [1:0]  size64;
  logic [31:0] addr64;
  logic [63:0] wdata64, ld64;

  logic        tbSel;
  logic        curStall, curReq, curWr, curDone, curAdel, curAdes;
  logic [1:0]  curSize;
  logic [31:0] curAddr;
  logic [63:0] curWdata;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] sbQ[$];
  logic        prevDone32 = 1'b0;
  logic        prevDone64 = 1'b0;

`ifdef MAU_PERF_CNT_EN
  logic [31:0] perfAcc32, perfStall32, perfAcc64, perfStall64;
  int          tbStall32 = 0;
  int          tbDone32 = 0;
`endif

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .cpu_clk(clk), .cpu_rst_n(rst_n), .acc_valid(valid32), .acc_wr(accWr),
    .acc_size(accSize), .acc_unsigned(accUns), .acc_addr(accAddr), .acc_wdata(accWdata[31:0]),
    .exc_in(excIn), .flush(flush), .pipe_go(pipeGo), .stall_o(stall32),
    .exc_adel_o(adel32), .exc_ades_o(ades32), .ld_data_o(ld32), .done_o(done32),
    .data_req(req32), .data_wr(wr32), .data_size(size32), .data_addr(addr32),
    .data_wdata(wdata32), .data_addr_ok(addrOk), .data_data_ok(dataOk),
    .data_rdata(dataRdata[31:0])
`ifdef MAU_PERF_CNT_EN
    , .perf_acc_cnt_o(perfAcc32), .perf_stall_cnt_o(perfStall32)
`endif
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .cpu_clk(clk), .cpu_rst_n(rst_n), .acc_valid(valid64), .acc_wr(accWr),
    .acc_size(accSize), .acc_unsigned(accUns), .acc_addr(accAddr), .acc_wdata(accWdata),
    .exc_in(excIn), .flush(flush), .pipe_go(pipeGo), .stall_o(stall64),
    .exc_adel_o(adel64), .exc_ades_o(ades64), .ld_data_o(ld64), .done_o(done64),
    .data_req(req64), .data_wr(wr64), .data_size(size64), .data_addr(addr64),
    .data_wdata(wdata64), .data_addr_ok(addrOk), .data_data_ok(dataOk),
    .data_rdata(dataRdata)
`ifdef MAU_PERF_CNT_EN
    , .perf_acc_cnt_o(perfAcc64), .perf_stall_cnt_o(perfStall64)
`endif
  );

  assign curStall = tbSel ? stall64 : stall32;
  assign curReq   = tbSel ? req64   : req32;
  assign curWr    = tbSel ? wr64    : wr32;
  assign curDone  = tbSel ? done64  : done32;
  assign curAdel  = tbSel ? adel64  : adel32;
  assign curAdes  = tbSel ? ades64  : ades32;
  assign curSize  = tbSel ? size64  : size32;
  assign curAddr  = tbSel ? addr64  : addr32;
  assign curWdata = tbSel ? wdata64 : {32'h0, wdata32};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Each retired access pops the oldest expected load result.
  always @(negedge clk) begin
    if (done32 && !prevDone32) begin
      if (sbQ.size() == 0) checkOutput("sbUnexpected32", 64'd1, 64'd0);
      else checkOutput("ldData32", {32'h0, ld32}, sbQ.pop_front());
    end
    if (done64 && !prevDone64) begin
      if (sbQ.size() == 0) checkOutput("sbUnexpected64", 64'd1, 64'd0);
      else checkOutput("ldData64", ld64, sbQ.pop_front());
    end
`ifdef MAU_PERF_CNT_EN
    if (!rst_n) begin
      tbStall32 = 0;
      tbDone32 = 0;
    end else begin
      if (stall32) tbStall32++;
      if (done32 && !prevDone32) tbDone32++;
    end
`endif
    prevDone32 = done32;
    prevDone64 = done64;
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".stall"}, {63'h0, stall32}, 64'h0);
    checkOutput({tag, ".done"},  {63'h0, done32},  64'h0);
    checkOutput({tag, ".req"},   {63'h0, req32},   64'h0);
    checkOutput({tag, ".wr"},    {63'h0, wr32},    64'h0);
    checkOutput({tag, ".size"},  {62'h0, size32},  64'h0);
    checkOutput({tag, ".addr"},  {32'h0, addr32},  64'h0);
    checkOutput({tag, ".wdata"}, {32'h0, wdata32}, 64'h0);
    checkOutput({tag, ".ld"},    {32'h0, ld32},    64'h0);
    checkOutput({tag, ".exc"},   {62'h0, adel32, ades32}, 64'h0);
    checkOutput({tag, ".req64"}, {63'h0, req64},   64'h0);
    checkOutput({tag, ".ld64"},  ld64,             64'h0);
  endtask

  task automatic applyStimulus(input string tag, input logic sel, input logic wr, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [63:0] wdata,
                               input logic [63:0] rdata, input int aok, input int dok, input int holdGo,
                               input logic [63:0] expLd, input logic [63:0] expWdata);
    int cyc = 0;
    int stallCnt = 0;
    int reqCnt = 0;
    int badBus = 0;
    int badHold = 0;
    bit seenDone = 0;
    @(posedge clk); #1;
    tbSel = sel; accWr = wr; accSize = size; accUns = uns; accAddr = addr; accWdata = wdata;
    excIn = 1'b0; flush = 1'b0; pipeGo = (holdGo == 0); dataRdata = rdata;
    valid32 = !sel; valid64 = sel;
    sbQ.push_back(expLd);
    while (!seenDone && cyc < 60) begin
      addrOk = (cyc == aok);
      dataOk = (cyc == aok + dok);
      @(negedge clk);
      if (curReq) begin
        reqCnt++;
        if (curAddr !== addr || curWr !== wr || curSize !== size || curWdata !== expWdata) badBus++;
      end
      if (curDone) seenDone = 1;
      else begin
        if (curStall) stallCnt++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!seenDone) begin
      checkOutput({tag, ".doneTimeout"}, 64'd0, 64'd1);
      void'(sbQ.pop_back());
    end else begin
      checkOutput({tag, ".stallCycles"}, 64'(stallCnt), 64'(aok + dok + 1));
      checkOutput({tag, ".reqCycles"}, 64'(reqCnt), 64'(aok + 1));
      checkOutput({tag, ".busFields"}, 64'(badBus), 64'd0);
      for (int h = 0; h < holdGo; h++) begin
        @(posedge clk); #1;
        if (h == holdGo - 1) pipeGo = 1'b1;
        @(negedge clk);
        if (curDone !== 1'b1 || curStall !== 1'b0) badHold++;
      end
      if (holdGo > 0) checkOutput({tag, ".doneHold"}, 64'(badHold), 64'd0);
    end
    @(posedge clk); #1;
    valid32 = 1'b0; valid64 = 1'b0; pipeGo = 1'b0; addrOk = 1'b0; dataOk = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".doneClear"}, {63'h0, curDone}, 64'h0);
  endtask

  task automatic checkException(input string tag, input logic sel, input logic wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic exc, input logic expAdel,
                                input logic expAdes);
    @(posedge clk); #1;
    tbSel = sel; accWr = wr; accSize = size; accAddr = addr; accUns = 1'b0; excIn = exc;
    addrOk = 1'b1; dataOk = 1'b1;
    valid32 = !sel; valid64 = sel;
    @(negedge clk);
    checkOutput({tag, ".adel"}, {63'h0, curAdel}, {63'h0, expAdel});
    checkOutput({tag, ".ades"}, {63'h0, curAdes}, {63'h0, expAdes});
    checkOutput({tag, ".noReq"}, {63'h0, curReq}, 64'h0);
    checkOutput({tag, ".noStall"}, {63'h0, curStall}, 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, ".stillIdle"}, {62'h0, curReq, curDone}, 64'h0);
    @(posedge clk); #1;
    valid32 = 1'b0; valid64 = 1'b0; excIn = 1'b0; addrOk = 1'b0; dataOk = 1'b0;
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; tbSel = 1'b0; valid32 = 1'b0; valid64 = 1'b0; accWr = 1'b0; accUns = 1'b0;
    excIn = 1'b0; flush = 1'b0; pipeGo = 1'b0; accSize = 2'd0; accAddr = '0; accWdata = '0;
    addrOk = 1'b0; dataOk = 1'b0; dataRdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst_n = 1'b1;

    applyStimulus("lw1000", 0, 0, SZ_WORD, 0, 32'h1000, 64'h0, 64'hDEADBEEF, 0, 3, 3, 64'hDEADBEEF, 64'h0);
    applyStimulus("lb1003", 0, 0, SZ_BYTE, 0, 32'h1003, 64'h0, 64'h80123456, 1, 1, 0, 64'hFFFFFF80, 64'h0);
    applyStimulus("lbu1003", 0, 0, SZ_BYTE, 1, 32'h1003, 64'h0, 64'h80123456, 0, 2, 0, 64'h00000080, 64'h0);
    applyStimulus("lh1002", 0, 0, SZ_HALF, 0, 32'h1002, 64'h0, 64'h80123456, 0, 0, 0, 64'hFFFF8012, 64'h0);
    applyStimulus("lhu1002", 0, 0, SZ_HALF, 1, 32'h1002, 64'h0, 64'h80123456, 2, 0, 1, 64'h00008012, 64'h0);

    checkException("sh2001", 0, 1, SZ_HALF, 32'h2001, 0, 0, 1);
    checkException("lw1002", 0, 0, SZ_WORD, 32'h1002, 0, 1, 0);
    checkException("excIn", 0, 0, SZ_WORD, 32'h1004, 1, 0, 0);
    applyStimulus("sh2002", 0, 1, SZ_HALF, 0, 32'h2002, 64'h1234, 64'h0, 0, 1, 0, 64'h0, 64'h12341234);
    applyStimulus("sb2003", 0, 1, SZ_BYTE, 0, 32'h2003, 64'h5A, 64'h0, 2, 0, 0, 64'h0, 64'h5A5A5A5A);

    // Flush while waiting for data: stale data_ok must be drained before the next access.
    @(posedge clk); #1;
    tbSel = 0; valid32 = 1; accWr = 0; accSize = SZ_WORD; accUns = 0; accAddr = 32'h3000;
    accWdata = '0; dataRdata = 64'h99999999; addrOk = 1; dataOk = 0; pipeGo = 1;
    @(negedge clk);
    checkOutput("flush.launchReq", {63'h0, req32}, 64'h1);
    @(posedge clk); #1;
    addrOk = 0; flush = 1; valid32 = 0;
    @(negedge clk);
    checkOutput("flush.waitStall", {63'h0, stall32}, 64'h1);
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    checkOutput("flush.drainStall", {62'h0, stall32, done32}, 64'h0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      valid32 = 1; accAddr = 32'h4000;
      dataOk = (k == 2);
      @(negedge clk);
      if (stall32 !== 1'b1 || req32 !== 1'b0) bad++;
    end
    checkOutput("flush.drainHold", 64'(bad), 64'd0);
    applyStimulus("afterDrain", 0, 0, SZ_WORD, 0, 32'h4000, 64'h0, 64'h11223344, 0, 1, 0, 64'h11223344, 64'h0);

    // Flush while the request is still waiting for addr_ok.
    @(posedge clk); #1;
    valid32 = 1; accWr = 0; accSize = SZ_WORD; accAddr = 32'h6000; addrOk = 0; dataOk = 0;
    @(posedge clk); #1;
    flush = 1; valid32 = 0;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    checkOutput("reqFlush.dropped", {62'h0, req32, stall32}, 64'h0);
    @(negedge clk);
    checkOutput("reqFlush.idle", {62'h0, req32, done32}, 64'h0);

    applyStimulus("swSlowAok", 0, 1, SZ_WORD, 0, 32'h5004, 64'h13572468, 64'h0, 5, 2, 0, 64'h0, 64'h13572468);

    // Asynchronous reset while a request is held in REQ.
    @(posedge clk); #1;
    valid32 = 1; accWr = 1; accSize = SZ_WORD; accAddr = 32'h5008; accWdata = 64'hA5A5A5A5;
    addrOk = 0; dataOk = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midReq.reqHigh", {63'h0, req32}, 64'h1);
    valid32 = 0;
    #1;
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("midReqReset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus("ld64_8", 1, 0, SZ_DWORD, 0, 32'h8, 64'h0, 64'h0123456789ABCDEF, 0, 1, 0,
                  64'h0123456789ABCDEF, 64'h0);
    applyStimulus("lw64_C", 1, 0, SZ_WORD, 0, 32'hC, 64'h0, 64'h80000000_12345678, 1, 0, 0,
                  64'hFFFFFFFF80000000, 64'h0);
    applyStimulus("sb64_13", 1, 1, SZ_BYTE, 0, 32'h13, 64'hAB, 64'h0, 0, 0, 0, 64'h0, 64'hABABABABABABABAB);
    applyStimulus("sw64_14", 1, 1, SZ_WORD, 0, 32'h14, 64'hCAFEF00D, 64'h0, 1, 1, 0, 64'h0,
                  64'hCAFEF00DCAFEF00D);
    checkException("ld64_4", 1, 0, SZ_DWORD, 32'h4, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
`ifdef MAU_PERF_CNT_EN
    checkOutput("perfStall32", {32'h0, perfStall32}, 64'(tbStall32));
    checkOutput("perfAcc32", {32'h0, perfAcc32}, 64'(tbDone32));
`endif
    checkOutput("sbEmpty", 64'(sbQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised data-side memory access unit for the MEM stage. It turns a pipeline load/store into an SRAM-like bus transaction (req/addr_ok/data_ok) and checks alignment. It generates byte-lane replicated write data and sign/zero-extends load data. It holds the pipeline with a stall until the transaction retires, and stays correct across flushes and exceptions while a request is outstanding.

Parameters:
DATA_W, 32, bus/register data width; 32 or 64 only
ADDR_W, 32, byte address width
NB, DATA_W/8, byte lanes (derived, localparam)

Ports:
cpu_clk  in  1  clock, rising edge
cpu_rst_n  in  1  asynchronous active-low reset
acc_valid  in  1  MEM stage holds a load/store this cycle
acc_wr  in  1  1 = store, 0 = load
acc_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64)
acc_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
acc_addr  in  ADDR_W  effective byte address
acc_wdata  in  DATA_W  store source register value
exc_in  in  1  upstream exception or interrupt already pending on this instruction
flush  in  1  pipeline flush (exception commit / eret)
pipe_go  in  1  downstream accepts MEM result this cycle
stall_o  out  1  hold IF..MEM
exc_adel_o  out  1  load address error
exc_ades_o  out  1  store address error
ld_data_o  out  DATA_W  extended load result, valid with done_o
done_o  out  1  access retired, result stable until pipe_go
data_req  out  1  bus request
data_wr  out  1  bus write
data_size  out  2  bus size, equal to acc_size
data_addr  out  ADDR_W  bus address, unaligned low bits preserved
data_wdata  out  DATA_W  lane-replicated store data
data_addr_ok  in  1  address handshake
data_data_ok  in  1  data handshake / write ack
data_rdata  in  DATA_W  raw read data

Behaviour:
- Reset: state IDLE; every output 0; latched address, size, op and data registers 0.
- misalign = address low bits not multiple of 2^acc_size. exc_adel_o = acc_valid & !acc_wr & misalign & !exc_in; exc_ades_o is the same with acc_wr. Both are combinational and never issue a bus request.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - acc_valid & !exc_in & !misalign & !flush -> drive data_req=1 with the bus fields the same cycle; go to REQ.
  - Any address error or exc_in -> stay IDLE, stall_o=0.
- REQ:
  - data_req held high with stable fields (latched at entry) until data_addr_ok.
  - On addr_ok -> WAIT. If addr_ok and data_ok arrive in the same cycle -> DONE.
  - flush before addr_ok -> drop req, go to IDLE. The bus never sees a partial request.
- WAIT: on data_ok, latch the extended rdata and go to DONE. flush while in WAIT -> DRAIN.
- DRAIN: stall_o=0, result discarded. On data_ok -> IDLE. New acc_valid is ignored, with stall_o=1, until the drain completes.
- DONE: done_o=1, stall_o=0. pipe_go -> IDLE. flush -> IDLE.
- stall_o = 1 in REQ and WAIT. stall_o = 1 in IDLE the cycle a request is launched. Otherwise 0.
- Store data replication:
  - byte: wdata[7:0] in every lane
  - half: wdata[15:0] in every half
  - word: the low word replicated (DATA_W=64)
  - dword: pass-through
- Load extraction: lane = addr[log2(NB)-1:0]. Select the sized field at lane*8, then sign- or zero-extend to DATA_W.
- At most one outstanding transaction. No request is issued while in DRAIN.

Optional Feature:
MAU_PERF_CNT_EN.
- With the macro: two 32-bit outputs, perf_acc_cnt_o and perf_stall_cnt_o.
  - perf_acc_cnt_o increments on every data_ok that reaches DONE.
  - perf_stall_cnt_o increments every cycle stall_o=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Without the macro: the ports and counters are absent.

Decomposition:
- Shared package/defines: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD), FSM state encodings, and EXC_ADEL/EXC_ADES codes reused by the exception logic.
- One sub-module, mau_lane_align: combinational store replication and load extract/extend, parametrised by DATA_W. It is reused for instruction-side fetch of 16-bit parcels later.

Test Plan:
1. LW at addr 0x1000, addr_ok same cycle, data_ok 3 cycles later with rdata 0xDEADBEEF:
   - stall_o high for 4 cycles
   - ld_data_o = 0xDEADBEEF
   - done_o until pipe_go
2. LB at 0x1003 with rdata 0x80xxxxxx -> ld_data_o = 0xFFFFFF80. LBU at the same address -> 0x00000080.
3. SH at 0x2001:
   - exc_ades_o = 1
   - data_req never asserted
   - stall_o = 0
   - SH at 0x2002 with wdata 0x1234 -> data_wdata = 0x12341234, data_size = 1.
4. flush asserted in WAIT after addr_ok:
   - stall_o drops, done_o is never asserted
   - the next acc_valid is held off until the stale data_ok arrives
   - no second data_req is issued before then
5. addr_ok held low for 5 cycles: data_addr, data_wr and data_size stay stable and data_req stays high all 5 cycles. Reset asserted mid-REQ -> all outputs return to 0 asynchronously.
6. DATA_W=64: LD at 0x8 passes rdata through unchanged. LW at 0xC with rdata upper word 0x8000_0000 -> sign-extended 0xFFFFFFFF80000000.
